// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_types
// Shared types for the LC-3b fetch stage.
//   lc3b_word      : 16-bit machine word (instructions and addresses)
//   fetch_state_t  : fetch controller states
//   PC_RESET       : address of the first fetch after reset
//   PC_STEP        : byte distance between consecutive instructions
// ---------------------------------------------------------------------------
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   // FETCH   : a read at pc is (or is about to be) outstanding
   // HOLD    : a second instruction arrived while decode was stalled;
   //           it waits in the hold buffer and no new read is issued
   // DISCARD : a redirect arrived while a read was in flight; that read
   //           must still complete, but its data is thrown away
   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   localparam lc3b_word PC_RESET = 16'h0000;
   localparam lc3b_word PC_STEP  = 16'h0002;

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction memory read port used by the fetch stage.
//   read    : read request, held until resp
//   address : fetch address, stable while read is high
//   rdata   : instruction word, valid only in the resp cycle
//   resp    : one-cycle pulse completing the outstanding read
// The master modport is the fetch stage; the slave modport is the memory.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
   import lc3b_types::*;

   logic     read;
   lc3b_word address;
   lc3b_word rdata;
   logic     resp;

   modport master (
      output read,
      output address,
      input  rdata,
      input  resp
   );

   modport slave (
      input  read,
      input  address,
      output rdata,
      output resp
   );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Program counter register for the fetch stage.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, loads PC_RESET
//   load  : when high, q takes d on the rising clock edge
//   d     : next program counter value
//   q     : current program counter value
// ---------------------------------------------------------------------------
module pc_reg
   import lc3b_types::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     load,
   input  lc3b_word d,
   output lc3b_word q
);

   // The pc only changes when the fetch controller asks for it, so the
   // register holds its value on every cycle without a load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= PC_RESET;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// LC-3b instruction fetch stage with a one-entry output slot, a one-entry
// hold buffer for decode back-pressure, and redirect handling that drops
// the data of any read that was in flight when the redirect arrived.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   imem        : instruction memory read port (master side)
//   redirect    : control-flow change from write-back
//   redirect_pc : redirect target, valid while redirect is high
//   id_ready    : decode accepts inst_out/pc_out this cycle
//   valid_out   : inst_out/pc_out hold a valid instruction
//   inst_out    : instruction word to decode
//   pc_out      : address of inst_out
// ---------------------------------------------------------------------------
module fetch_stage
   import lc3b_types::*;
(
   input  logic             clk,
   input  logic             rst_n,
   fetch_stage_if.master    imem,
   input  logic             redirect,
   input  lc3b_word         redirect_pc,
   input  logic             id_ready,
   output logic             valid_out,
   output lc3b_word         inst_out,
   output lc3b_word         pc_out
);

   fetch_state_t state;
   fetch_state_t state_next;

   lc3b_word pc;
   lc3b_word pc_next;
   logic     pc_load;
   lc3b_word pc_inc;

   lc3b_word stale_addr;
   lc3b_word stale_next;

   logic     valid_next;
   lc3b_word inst_next;
   lc3b_word pc_out_next;

   lc3b_word hold_inst;
   lc3b_word hold_pc;
   lc3b_word hold_inst_next;
   lc3b_word hold_pc_next;

   logic     slot_free;

   // 16-bit addition wraps naturally, so FFFE steps to 0000.
   assign pc_inc    = pc + PC_STEP;

   // The slot can take a new word if it is empty or is being drained now.
   assign slot_free = !valid_out || id_ready;

   pc_reg u_pc_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (pc_load),
      .d     (pc_next),
      .q     (pc)
   );

   // State, stale address, output slot and hold buffer registers. The hold
   // buffer has no valid bit of its own: it is occupied exactly while the
   // controller sits in HOLD, so leaving HOLD invalidates it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FETCH;
         stale_addr <= PC_RESET;
         valid_out  <= 1'b0;
         inst_out   <= 16'h0000;
         pc_out     <= 16'h0000;
         hold_inst  <= 16'h0000;
         hold_pc    <= 16'h0000;
      end else begin
         state      <= state_next;
         stale_addr <= stale_next;
         valid_out  <= valid_next;
         inst_out   <= inst_next;
         pc_out     <= pc_out_next;
         hold_inst  <= hold_inst_next;
         hold_pc    <= hold_pc_next;
      end
   end

   // Next-state and output logic. By default the slot empties when decode
   // takes it and everything else holds. A redirect is checked first in
   // every state because it overrides any response or hand-off in the same
   // cycle; the only thing that differs per state is whether a read is
   // still outstanding afterwards (FETCH without resp goes to DISCARD so
   // the old read can drain at its original address).
   always_comb begin
      state_next     = state;
      pc_load        = 1'b0;
      pc_next        = pc_inc;
      stale_next     = stale_addr;
      valid_next     = valid_out && !id_ready;
      inst_next      = inst_out;
      pc_out_next    = pc_out;
      hold_inst_next = hold_inst;
      hold_pc_next   = hold_pc;
      imem.read      = 1'b1;
      imem.address   = pc;

      case (state)
         FETCH: begin
            if (redirect) begin
               valid_next = 1'b0;
               pc_load    = 1'b1;
               pc_next    = redirect_pc;
               if (!imem.resp) begin
                  stale_next = pc;
                  state_next = DISCARD;
               end
            end else if (imem.resp) begin
               pc_load = 1'b1;
               if (slot_free) begin
                  valid_next  = 1'b1;
                  inst_next   = imem.rdata;
                  pc_out_next = pc;
               end else begin
                  hold_inst_next = imem.rdata;
                  hold_pc_next   = pc;
                  state_next     = HOLD;
               end
            end
         end

         HOLD: begin
            imem.read = 1'b0;
            if (redirect) begin
               valid_next = 1'b0;
               pc_load    = 1'b1;
               pc_next    = redirect_pc;
               state_next = FETCH;
            end else if (id_ready) begin
               valid_next  = 1'b1;
               inst_next   = hold_inst;
               pc_out_next = hold_pc;
               state_next  = FETCH;
            end
         end

         DISCARD: begin
            imem.address = stale_addr;
            if (redirect) begin
               valid_next = 1'b0;
               pc_load    = 1'b1;
               pc_next    = redirect_pc;
            end else if (imem.resp) begin
               state_next = FETCH;
            end
         end

         default: begin
            state_next = FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized run against a memory model and an instruction-stream
// scoreboard.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
   import lc3b_types::*;

   logic     clk;
   logic     rst_n;
   logic     redirect;
   lc3b_word redirect_pc;
   logic     id_ready;
   logic     valid_out;
   lc3b_word inst_out;
   lc3b_word pc_out;

   fetch_stage_if imem_bus ();

   int checks = 0;
   int errors = 0;
   int xfers  = 0;

   logic     mem_auto = 1'b0;
   logic     mon_en   = 1'b0;
   int       wait_cnt = 0;
   lc3b_word exp_pc   = 16'h0000;
   lc3b_word redir_q[$];

   fetch_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (imem_bus.master),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_ready    (id_ready),
      .valid_out   (valid_out),
      .inst_out    (inst_out),
      .pc_out      (pc_out)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not finish (got running, want finished)");
      $fatal(1, "[TB] timeout");
   end

   // Memory contents: a byte-swap plus xor, so every address has a unique word.
   function automatic lc3b_word memf(input lc3b_word a);
      return {a[7:0], a[15:8]} ^ 16'h5A5A;
   endfunction

   task automatic checkOutput(input string name, input lc3b_word act, input lc3b_word exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of directed inputs; resp/redirect are one-cycle pulses.
   task automatic applyStimulus(input logic r, input lc3b_word rd, input logic rdr,
                                input lc3b_word rpc, input logic rdy);
      imem_bus.resp  = r;
      imem_bus.rdata = rd;
      redirect       = rdr;
      redirect_pc    = rpc;
      id_ready       = rdy;
      tick();
      imem_bus.resp  = 1'b0;
      redirect       = 1'b0;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Randomized memory: answers each read after 0..2 cycles of read high
   // with the word stored at the requested address.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mem_auto) begin
            imem_bus.resp = 1'b0;
            if (imem_bus.read) begin
               if (wait_cnt == 0) begin
                  imem_bus.resp  = 1'b1;
                  imem_bus.rdata = memf(imem_bus.address);
                  wait_cnt       = $urandom_range(0, 2);
               end else begin
                  wait_cnt--;
               end
            end
         end
      end
   end

   // Scoreboard monitor: the instruction stream must be the sequential
   // addresses from the last redirect target (or reset), each carrying its
   // memory word. A hand-off in a redirect cycle still counts as delivered.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (valid_out && id_ready) begin
               checkOutput("stream pc_out", pc_out, exp_pc);
               checkOutput("stream inst_out", inst_out, memf(exp_pc));
               exp_pc = exp_pc + 16'h0002;
               xfers++;
            end
            if (redirect) begin
               if (redir_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL redirect queue: got empty, want entry");
               end else begin
                  exp_pc = redir_q.pop_front();
               end
            end
         end
      end
   end

   initial begin
      rst_n          = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = 16'h0000;
      id_ready       = 1'b0;
      imem_bus.resp  = 1'b0;
      imem_bus.rdata = 16'h0000;

      // Reset state
      #3;
      checkOutput("reset valid_out", {15'd0, valid_out}, 16'h0000);
      checkOutput("reset inst_out", inst_out, 16'h0000);
      checkOutput("reset pc_out", pc_out, 16'h0000);
      checkOutput("reset imem_address", imem_bus.address, 16'h0000);
      tick();
      rst_n = 1'b1;
      checkOutput("post-reset imem_read", {15'd0, imem_bus.read}, 16'h0001);

      // Two back-to-back instructions with decode always ready
      applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1);
      checkOutput("seq pc_out 0", pc_out, 16'h0000);
      checkOutput("seq inst_out 0", inst_out, 16'h1234);
      checkOutput("seq address 2", imem_bus.address, 16'h0002);
      applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
      applyStimulus(1'b1, 16'h5678, 1'b0, 16'h0000, 1'b1);
      checkOutput("seq valid 2", {15'd0, valid_out}, 16'h0001);
      checkOutput("seq pc_out 2", pc_out, 16'h0002);
      checkOutput("seq inst_out 2", inst_out, 16'h5678);

      // Decode stall fills slot and hold buffer
      doReset();
      applyStimulus(1'b1, 16'hAAAA, 1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b1, 16'hBBBB, 1'b0, 16'h0000, 1'b0);
      checkOutput("stall imem_read", {15'd0, imem_bus.read}, 16'h0000);
      checkOutput("stall inst_out", inst_out, 16'hAAAA);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      checkOutput("stall held inst_out", inst_out, 16'hAAAA);
      checkOutput("stall held pc_out", pc_out, 16'h0000);
      checkOutput("stall held imem_read", {15'd0, imem_bus.read}, 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
      checkOutput("unstall inst_out", inst_out, 16'hBBBB);
      checkOutput("unstall pc_out", pc_out, 16'h0002);
      checkOutput("unstall imem_read", {15'd0, imem_bus.read}, 16'h0001);
      checkOutput("unstall address", imem_bus.address, 16'h0004);
      applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
      checkOutput("unstall drained", {15'd0, valid_out}, 16'h0000);

      // Redirect with read outstanding: stale data must be discarded
      applyStimulus(1'b0, 16'h0000, 1'b1, 16'h3000, 1'b1);
      checkOutput("discard address", imem_bus.address, 16'h0004);
      checkOutput("discard imem_read", {15'd0, imem_bus.read}, 16'h0001);
      applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
      checkOutput("discard address hold", imem_bus.address, 16'h0004);
      applyStimulus(1'b1, 16'hDEAD, 1'b0, 16'h0000, 1'b1);
      checkOutput("discard valid_out", {15'd0, valid_out}, 16'h0000);
      checkOutput("discard next address", imem_bus.address, 16'h3000);

      // Redirect coincident with a response
      applyStimulus(1'b1, 16'h1111, 1'b1, 16'h4000, 1'b1);
      checkOutput("coincident valid_out", {15'd0, valid_out}, 16'h0000);
      checkOutput("coincident address", imem_bus.address, 16'h4000);

      // pc wrap at FFFE
      applyStimulus(1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b1);
      checkOutput("wrap stale address", imem_bus.address, 16'h4000);
      applyStimulus(1'b1, 16'h2222, 1'b0, 16'h0000, 1'b1);
      checkOutput("wrap fetch address", imem_bus.address, 16'hFFFE);
      applyStimulus(1'b1, 16'h7777, 1'b0, 16'h0000, 1'b1);
      checkOutput("wrap pc_out", pc_out, 16'hFFFE);
      checkOutput("wrap inst_out", inst_out, 16'h7777);
      checkOutput("wrap next address", imem_bus.address, 16'h0000);

      // Reset while slot full and hold buffer occupied
      applyStimulus(1'b1, 16'h8888, 1'b0, 16'h0000, 1'b0);
      checkOutput("pre-reset imem_read", {15'd0, imem_bus.read}, 16'h0000);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset valid_out", {15'd0, valid_out}, 16'h0000);
      checkOutput("async reset inst_out", inst_out, 16'h0000);
      checkOutput("async reset pc_out", pc_out, 16'h0000);
      checkOutput("async reset address", imem_bus.address, 16'h0000);
      tick();
      rst_n = 1'b1;
      checkOutput("release imem_read", {15'd0, imem_bus.read}, 16'h0001);
      applyStimulus(1'b1, 16'h9999, 1'b0, 16'h0000, 1'b1);
      checkOutput("first resp valid", {15'd0, valid_out}, 16'h0001);
      checkOutput("first resp pc_out", pc_out, 16'h0000);
      checkOutput("first resp inst_out", inst_out, 16'h9999);

      // Randomized run against the memory model and stream scoreboard
      doReset();
      exp_pc   = PC_RESET;
      wait_cnt = 0;
      mem_auto = 1'b1;
      mon_en   = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         id_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 24) == 0) begin
            redirect = 1'b1;
            if ($urandom_range(0, 3) == 0)
               redirect_pc = 16'hFFF8;
            else
               redirect_pc = lc3b_word'($urandom) & 16'hFFFE;
            redir_q.push_back(redirect_pc);
         end else begin
            redirect = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      redirect = 1'b0;
      id_ready = 1'b0;
      @(negedge clk);
      mon_en   = 1'b0;
      mem_auto = 1'b0;

      checks++;
      if (xfers < 500) begin
         errors++;
         $display("[TB] FAIL random throughput: got %0d transfers, want at least 500", xfers);
      end
      checkOutput("redirect queue drained", 16'(redir_q.size()), 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 imem_read  output  1  instruction memory read request; held high until imem_resp.
REQ-004 imem_address  output  16 (lc3b_word)  instruction fetch address; stable while imem_read high.
REQ-005 imem_rdata  input  16 (lc3b_word)  instruction word; valid only in the imem_resp cycle.
REQ-006 imem_resp  input  1  one-cycle pulse completing the outstanding read.
REQ-007 redirect  input  1  control-flow change from WB (branch, JMP, JSR, TRAP).
REQ-008 redirect_pc  input  16  target address; valid when redirect high.
REQ-009 id_ready  input  1  decode accepts inst_out/pc_out this cycle.
REQ-010 valid_out  output  1  inst_out/pc_out hold a valid instruction.
REQ-011 inst_out  output  16  instruction word to the decode/ipacket stage.
REQ-012 pc_out  output  16  address of inst_out (decode adds 2).

Function
REQ-013 States SHALL be FETCH, HOLD, DISCARD; registers: pc, stale_addr, output slot (valid_out/inst_out/pc_out), hold buffer (hold_inst/hold_pc).
REQ-014 FETCH: imem_read=1, imem_address=pc. HOLD: imem_read=0, imem_address=pc. DISCARD: imem_read=1, imem_address=stale_addr.
REQ-015 Transfer to decode SHALL occur when valid_out && id_ready; valid_out drops next cycle unless refilled.
REQ-016 FETCH, imem_resp, no redirect, slot free (!valid_out or id_ready): slot <= {imem_rdata, pc}, valid_out <= 1, pc <= pc+16'h2, stay FETCH.
REQ-017 FETCH, imem_resp, no redirect, slot full and !id_ready: hold buffer <= {imem_rdata, pc}, pc <= pc+2, go HOLD.
REQ-018 HOLD, id_ready, no redirect: slot <= hold buffer, valid_out stays 1, go FETCH.
REQ-019 Redirect, any state: valid_out <= 0, hold buffer invalidated; redirect overrides every other same-cycle event.
REQ-020 Redirect in FETCH with imem_resp same cycle: imem_rdata dropped, pc <= redirect_pc, stay FETCH.
REQ-021 Redirect in FETCH without imem_resp: stale_addr <= pc, pc <= redirect_pc, go DISCARD.
REQ-022 Redirect in HOLD: pc <= redirect_pc, go FETCH.
REQ-023 Redirect in DISCARD: pc <= redirect_pc, stale_addr unchanged, stay DISCARD.
REQ-024 DISCARD, imem_resp: imem_rdata dropped, go FETCH; new request at pc next cycle.
REQ-025 pc arithmetic SHALL be 16-bit modular; 16'hFFFE+2 wraps to 16'h0000.
REQ-026 Best-case latency: one instruction per imem_resp; inst_out valid the cycle after imem_resp.
REQ-027 No instruction SHALL be presented twice, skipped, or reordered absent redirect.

Reset
REQ-028 On rst_n low, asynchronously: state=FETCH, pc=16'h0000, stale_addr=16'h0000, valid_out=0, inst_out=16'h0000, pc_out=16'h0000, hold buffer cleared.
REQ-029 Reset mid-request SHALL abandon the read; first post-reset request is to 16'h0000; an imem_resp in the first post-reset cycle is accepted as the 16'h0000 response.

Structure
REQ-030 lc3b_word and a new enum fetch_state_t {FETCH, HOLD, DISCARD} SHALL live in package lc3b_types; reset vector constant PC_RESET = 16'h0000 also there.
REQ-031 Single sub-module pc_reg (16-bit, load-enabled, async active-low reset) holds pc; everything else is in fetch_stage.

Verification
REQ-032 Reset, imem_resp each 2nd cycle, rdata=16'h1234/16'h5678, id_ready=1 -> imem_address 0000 then 0002; pc_out 0000/0002 with matching inst_out.
REQ-033 id_ready=0 for 6 cycles, two responses (A at 0000, B at 0002) -> slot=A, state HOLD, imem_read=0; id_ready=1 -> A consumed, then B, fetch resumes at 0004.
REQ-034 Redirect to 16'h3000 while read to 0004 outstanding, no resp -> DISCARD, imem_address stays 0004; resp(16'hDEAD) dropped; next request address 3000; valid_out never shows DEAD.
REQ-035 Redirect to 16'h4000 coincident with imem_resp -> data dropped, valid_out=0 next cycle, next imem_address 4000.
REQ-036 pc=16'hFFFE, resp -> pc_out FFFE, next imem_address 0000.
REQ-037 rst_n low mid-request with valid_out=1 and HOLD occupied -> all outputs zero immediately; after release imem_address 0000, imem_read 1.
